// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal entry assembler.
package decimal_entry_pkg;

    typedef enum logic [1:0] {ENTRY, CONVERT, DONE} entry_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_stack.sv
// NUM_DIGITS x 4-bit BCD shift stack; [3:0] is the least significant digit.
module bcd_digit_stack #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clr,
    input  logic                    load_one,
    input  logic [3:0]              din,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [CNT_W-1:0]        count
);

    // Caller asserts at most one operation per cycle; clr wins regardless.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            digits <= '0;
            count  <= '0;
        end else if (load_one) begin
            digits <= {{(4*NUM_DIGITS-4){1'b0}}, din};
            count  <= CNT_W'(1);
        end else if (push) begin
            digits <= {digits[4*NUM_DIGITS-5:0], din};
            count  <= count + CNT_W'(1);
        end else if (pop) begin
            digits <= {4'h0, digits[4*NUM_DIGITS-1:4]};
            count  <= (count == '0) ? '0 : count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/decimal_entry_assembler.sv
// Collects BCD digits MSD-first and converts them to binary on 'enter',
// one digit per cycle via multiply-by-ten accumulate.
module decimal_entry_assembler
    import decimal_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        digit_in,
    input  logic                              digit_valid,
    input  logic                              backspace,
    input  logic                              clear,
    input  logic                              enter,
    output logic [4*NUM_DIGITS-1:0]           digits_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              busy,
    output logic [OUT_WIDTH-1:0]              value_out,
    output logic                              value_valid,
    output logic                              entry_error
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (((pow10(NUM_DIGITS) - 64'd1) >> OUT_WIDTH) != 64'd0) begin : g_width_check
        $error("OUT_WIDTH too narrow for NUM_DIGITS decimal digits");
    end

    entry_state_t         state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic [OUT_WIDTH-1:0] value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    logic       st_push, st_pop, st_clr, st_load;
    logic [3:0] cur_digit;
    logic       digit_ok;
    logic [OUT_WIDTH-1:0] acc_x10;

    bcd_digit_stack #(
        .NUM_DIGITS(NUM_DIGITS),
        .CNT_W     (CNT_W)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (st_push),
        .pop     (st_pop),
        .clr     (st_clr),
        .load_one(st_load),
        .din     (digit_in),
        .digits  (digits_bcd),
        .count   (digit_count)
    );

    assign cur_digit = digits_bcd[{idx_q, 2'b00} +: 4];
    assign digit_ok  = (digit_in <= BCD_MAX);
    assign acc_x10   = (acc_q << 3) + (acc_q << 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTRY;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        value_d = value_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_clr  = 1'b0;
        st_load = 1'b0;
        unique case (state_q)
            ENTRY: begin
                if (clear) begin
                    st_clr = 1'b1;
                end else if (enter) begin
                    state_d = CONVERT;
                    acc_d   = '0;
                    idx_d   = IDX_W'(NUM_DIGITS - 1);
                    busy_d  = 1'b1;
                end else if (backspace) begin
                    st_pop = 1'b1;
                end else if (digit_valid) begin
                    if (digit_ok && (digit_count < CNT_W'(NUM_DIGITS))) st_push = 1'b1;
                    else err_d = 1'b1;
                end
            end
            CONVERT: begin
                // busy_q low marks the extra cycle that publishes the result.
                if (clear) begin
                    st_clr  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ENTRY;
                end else if (busy_q) begin
                    acc_d = acc_x10 + OUT_WIDTH'(cur_digit);
                    if (idx_q == '0) busy_d = 1'b0;
                    else idx_d = idx_q - IDX_W'(1);
                end else begin
                    value_d = acc_q;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    st_clr  = 1'b1;
                    valid_d = 1'b0;
                    value_d = '0;
                    state_d = ENTRY;
                end else if (backspace) begin
                    st_pop  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ENTRY;
                end else if (digit_valid) begin
                    if (digit_ok) begin
                        st_load = 1'b1;
                        valid_d = 1'b0;
                        state_d = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    assign busy        = busy_q;
    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign entry_error = err_q;

endmodule

// File: tb/tb_decimal_entry_assembler.sv
// Directed self-checking bench for decimal_entry_assembler (4 digits, 16-bit result).
module tb_decimal_entry_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_valid = 1'b0;
    logic        backspace = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] digits_bcd;
    logic [2:0]  digit_count;
    logic        busy;
    logic [15:0] value_out;
    logic        value_valid;
    logic        entry_error;

    int n_cmp = 0;
    int n_fail = 0;

    decimal_entry_assembler #(
        .NUM_DIGITS(4),
        .OUT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_in   (digit_in),
        .digit_valid(digit_valid),
        .backspace  (backspace),
        .clear      (clear),
        .enter      (enter),
        .digits_bcd (digits_bcd),
        .digit_count(digit_count),
        .busy       (busy),
        .value_out  (value_out),
        .value_valid(value_valid),
        .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    // Strobes: raise at a negedge, drop at the next; the DUT sees one posedge in between.
    task automatic press_digit(input logic [3:0] d);
        @(negedge clk); digit_in = d; digit_valid = 1'b1;
        @(negedge clk); digit_valid = 1'b0;
    endtask

    task automatic press_enter();
        @(negedge clk); enter = 1'b1;
        @(negedge clk); enter = 1'b0;
    endtask

    task automatic press_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic press_backspace();
        @(negedge clk); backspace = 1'b1;
        @(negedge clk); backspace = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (value_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (value_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: value_valid=%b after %0d cycles, required 1", tag,
                     value_valid, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({digits_bcd, digit_count, busy, value_out, value_valid, entry_error} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: digits=%h cnt=%0d busy=%b val=%0d vv=%b err=%b, required all 0",
                     digits_bcd, digit_count, busy, value_out, value_valid, entry_error);
        end
    endtask

    task automatic test_basic();
        logic exp_busy, exp_valid;
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        n_cmp++;
        if (digits_bcd !== 16'h1234 || digit_count !== 3'd4) begin
            n_fail++;
            $display("FAIL basic_stack: digits=%h cnt=%0d, required 1234 cnt=4",
                     digits_bcd, digit_count);
        end
        press_enter();
        // k counts edges after the one that sampled enter.
        for (int k = 0; k <= 5; k++) begin
            exp_busy  = (k < 4);
            exp_valid = (k == 5);
            n_cmp++;
            if (busy !== exp_busy || value_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL basic_timing_k%0d: busy=%b vv=%b, required busy=%b vv=%b",
                         k, busy, value_valid, exp_busy, exp_valid);
            end
            if (k < 5) @(negedge clk);
        end
        n_cmp++;
        if (value_out !== 16'd1234 || digits_bcd !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_value: value=%0d digits=%h, required 1234 / 1234",
                     value_out, digits_bcd);
        end
        press_enter();
        n_cmp++;
        if (value_valid !== 1'b1 || busy !== 1'b0 || value_out !== 16'd1234) begin
            n_fail++;
            $display("FAIL done_enter_ignored: vv=%b busy=%b value=%0d, required 1 0 1234",
                     value_valid, busy, value_out);
        end
    endtask

    task automatic test_overflow();
        press_clear();
        n_cmp++;
        if (value_valid !== 1'b0 || value_out !== 16'd0 || digit_count !== 3'd0) begin
            n_fail++;
            $display("FAIL done_clear: vv=%b value=%0d cnt=%0d, required 0 0 0",
                     value_valid, value_out, digit_count);
        end
        repeat (4) press_digit(4'd9);
        press_digit(4'd5);
        n_cmp++;
        if (entry_error !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_err: entry_error=%b, required 1", entry_error);
        end
        @(negedge clk);
        n_cmp++;
        if (entry_error !== 1'b0 || digits_bcd !== 16'h9999 || digit_count !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_stack: err=%b digits=%h cnt=%0d, required 0 9999 4",
                     entry_error, digits_bcd, digit_count);
        end
        press_enter();
        wait_valid("overflow");
        n_cmp++;
        if (value_out !== 16'd9999) begin
            n_fail++;
            $display("FAIL overflow_value: value=%0d, required 9999", value_out);
        end
    endtask

    task automatic test_invalid_digit();
        press_clear();
        press_digit(4'hA);
        n_cmp++;
        if (entry_error !== 1'b1 || digit_count !== 3'd0) begin
            n_fail++;
            $display("FAIL invalid_digit: err=%b cnt=%0d, required 1 0", entry_error, digit_count);
        end
        press_digit(4'd7);
        press_backspace();
        n_cmp++;
        if (digit_count !== 3'd0 || digits_bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL backspace: cnt=%0d digits=%h, required 0 0000", digit_count, digits_bcd);
        end
        press_digit(4'd3);
        press_enter();
        wait_valid("invalid");
        n_cmp++;
        if (value_out !== 16'd3 || digits_bcd !== 16'h0003) begin
            n_fail++;
            $display("FAIL invalid_value: value=%0d digits=%h, required 3 0003",
                     value_out, digits_bcd);
        end
    endtask

    task automatic test_empty_enter();
        press_clear();
        press_enter();
        wait_valid("empty");
        n_cmp++;
        if (value_out !== 16'd0 || value_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_value: value=%0d vv=%b, required 0 1", value_out, value_valid);
        end
    endtask

    task automatic test_abort();
        int seen;
        press_clear();
        press_digit(4'd5); press_digit(4'd6);
        press_enter();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || digit_count !== 3'd0 || digits_bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b cnt=%0d digits=%h, required 0 0 0000",
                     busy, digit_count, digits_bcd);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (value_valid === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: busy/valid high in %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_done_edits();
        press_clear();
        press_digit(4'd4); press_digit(4'd2);
        press_enter();
        wait_valid("done42");
        n_cmp++;
        if (value_out !== 16'd42) begin
            n_fail++;
            $display("FAIL done_value: value=%0d, required 42", value_out);
        end
        press_digit(4'hF);
        n_cmp++;
        if (entry_error !== 1'b1 || value_valid !== 1'b1 || digits_bcd !== 16'h0042) begin
            n_fail++;
            $display("FAIL done_invalid: err=%b vv=%b digits=%h, required 1 1 0042",
                     entry_error, value_valid, digits_bcd);
        end
        press_backspace();
        n_cmp++;
        if (value_valid !== 1'b0 || digits_bcd !== 16'h0004 || digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL done_backspace: vv=%b digits=%h cnt=%0d, required 0 0004 1",
                     value_valid, digits_bcd, digit_count);
        end
        press_enter();
        wait_valid("done4");
        press_digit(4'd8);
        n_cmp++;
        if (value_valid !== 1'b0 || digits_bcd !== 16'h0008 || digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL done_fresh: vv=%b digits=%h cnt=%0d, required 0 0008 1",
                     value_valid, digits_bcd, digit_count);
        end
    endtask

    task automatic test_reset_mid_convert();
        press_enter();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midconv_busy: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({digits_bcd, digit_count, busy, value_out, value_valid, entry_error} !== 38'd0) begin
            n_fail++;
            $display("FAIL midconv_reset: digits=%h cnt=%0d busy=%b val=%0d vv=%b err=%b, required all 0",
                     digits_bcd, digit_count, busy, value_out, value_valid, entry_error);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (value_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midconv_quiet: vv=%b busy=%b, required 0 0", value_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_invalid_digit();
        test_empty_enter();
        test_abort();
        test_done_edits();
        test_reset_mid_convert();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
